mips_lsu: RTL

Load/store unit sitting between the MIPS execute/memory stage and the data port of the unified byte-addressable memory.
- Accepts lb/lbu/lh/lhu/lw/sb/sh/sw requests.
- Drives the memory's word-wide data port: word-aligned address, mem_read, mem_write, data_in; consumes the combinational read data.
- Performs byte-lane extraction and sign extension on loads.
- Performs read-modify-write for sub-word stores, because the memory writes only full words.

---
 rtl/mips_lsu_pkg.sv | 27 ++
 rtl/mips_lsu_if.sv | 32 +++
 rtl/mips_lsu_lane_align.sv | 34 +++
 rtl/mips_lsu.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared encodings, state type and defaults for the MIPS load/store unit
package mips_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] MEM_SIZE_DEFAULT = 32'h0000_2000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP,
        ST_ERR
    } lsu_state_t;

    // Natural alignment of the low address bits: half clears [0], word clears [1:0].
    function automatic logic [1:0] align_lo(input logic [1:0] lo, input logic [1:0] size);
        case (size)
            SZ_HALF: align_lo = {lo[1], 1'b0};
            SZ_WORD: align_lo = 2'b00;
            default: align_lo = lo;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// rtl/mips_lsu_if.sv - request/response and memory data-port bundle of the load/store unit
interface mips_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_read, mem_write, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/mips_lsu_lane_align.sv
// rtl/mips_lsu_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rword[{lo, 3'b000} +: 8];
        lane_h = rword[{lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: load_data = {{24{sgn & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{sgn & lane_h[15]}}, lane_h};
            default: load_data = rword;
        endcase
    end

    always_comb begin
        store_word = rword;
        case (size)
            SZ_BYTE: store_word[{lo, 3'b000} +: 8]   = wdata[7:0];
            SZ_HALF: store_word[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end
endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - MIPS load/store unit with sub-word RMW; `define MIPS_LSU_MISALIGN_TRAP_EN traps misaligned accesses
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    mips_lsu_if.slave    bus
);
    lsu_state_t        state, state_n;
    logic              r_we;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rword;

    logic              accept;
    logic              req_err;
    logic              size_bad;
    logic              out_of_range;
    logic              misaligned;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign accept = bus.req_valid && (state == ST_IDLE);

    always_comb begin
        size_bad     = (bus.req_size == 2'b11);
        out_of_range = (bus.req_addr >= ADDR_W'(MEM_SIZE));
        misaligned   = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                       ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
        cap_addr     = bus.req_addr;
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
        req_err      = size_bad || out_of_range || misaligned;
`else
        // Misaligned accesses silently snap to natural alignment.
        req_err      = size_bad || out_of_range;
        cap_addr[1:0] = align_lo(bus.req_addr[1:0], bus.req_size);
`endif
    end

    lsu_lane_align u_align (
        .lo         (r_addr[1:0]),
        .size       (r_size),
        .sgn        (r_signed),
        .rword      (r_rword),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= SZ_BYTE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rword  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                r_we     <= bus.req_we;
                r_signed <= bus.req_signed;
                r_size   <= bus.req_size;
                r_addr   <= cap_addr;
                r_wdata  <= bus.req_wdata;
            end
            if (state == ST_RD) begin
                r_rword <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_n = ST_ERR;
                    else if (!bus.req_we || (bus.req_size != SZ_WORD))
                        state_n = ST_RD;
                    else
                        state_n = ST_WR;
                end
            end
            ST_RD:   state_n = r_we ? ST_WR : ST_RESP;
            ST_WR:   state_n = ST_RESP;
            ST_RESP: state_n = ST_IDLE;
            ST_ERR:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == ST_IDLE);
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_wdata  = '0;
        case (state)
            ST_RD: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
            end
            ST_WR: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
                bus.mem_wdata = store_word;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = r_we ? 32'h0 : load_data;
            end
            ST_ERR: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
